// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: arbitrates MEM-stage and external requests onto a
// single-port memory with a fixed read latency, stalling the pipeline until done.
module dm_access_ctrl #(
  parameter int AW         = 7,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_rd,
  input  logic          pipe_wr,
  input  logic [31:0]   pipe_addr,
  input  logic [31:0]   pipe_wdata,
  output logic          pipe_stall,
  output logic          pipe_done,
  output logic [31:0]   pipe_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_ack,
  output logic [31:0]   ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_PIPE, OWN_EXT} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [SCW-1:0]  starve_q, starve_d;
  logic [31:0]     pipe_rdata_q, pipe_rdata_d;
  logic [31:0]     ext_rdata_q, ext_rdata_d;

  logic pipe_req;
  logic grant_ext;
  logic unused_addr_bits;

  assign pipe_req         = pipe_rd | pipe_wr;
  assign unused_addr_bits = ^pipe_addr[31:AW];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    pipe_rdata_d = pipe_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    grant_ext    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!ext_req) begin
          starve_d = '0;
        end
        if (pipe_req || ext_req) begin
          grant_ext = ext_req && (!pipe_req || starve_q == SCW'(STARVE_MAX));
          state_d   = S_ISSUE;
          if (grant_ext) begin
            owner_d  = OWN_EXT;
            we_d     = ext_we;
            addr_d   = ext_addr;
            wdata_d  = ext_wdata;
            starve_d = '0;
          end else begin
            // A simultaneous rd+wr is a store; the read is dropped.
            owner_d = OWN_PIPE;
            we_d    = pipe_wr;
            addr_d  = pipe_addr[AW-1:0];
            wdata_d = pipe_wdata;
            if (ext_req && starve_q != SCW'(STARVE_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        wait_d  = WCW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_PIPE) pipe_rdata_d = mem_rdata;
            else                     ext_rdata_d  = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_PIPE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_q       <= '0;
      starve_q     <= '0;
      pipe_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      pipe_rdata_q <= pipe_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign mem_en     = (state_q == S_ISSUE);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign pipe_done  = (state_q == S_DONE) && (owner_q == OWN_PIPE);
  assign ext_ack    = (state_q == S_DONE) && (owner_q == OWN_EXT);
  assign pipe_stall = pipe_req & ~pipe_done;
  assign pipe_rdata = pipe_rdata_q;
  assign ext_rdata  = ext_rdata_q;

endmodule
